// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a serialized update path.
//
// Lookup is purely combinational against the table contents as of the last
// clock edge. Updates from the execute stage are accepted in IDLE, then walk
// through READ (current counter offered to the external 2-bit counter FSM)
// and WRITE (returned counter, and target if needed, written back).
//
// Ports:
//   btb_clk, btb_rst              clock, asynchronous active-high reset
//   btb_fetch_pc                  fetch PC to look up
//   btb_hit / btb_predict_taken   lookup result and predicted direction
//   btb_predicted_target          stored target on hit, zero otherwise
//   btb_update_valid/ready        resolved-branch handshake (ready only in IDLE)
//   btb_update_pc/taken/target    resolved branch information
//   btb_flush                     synchronous invalidate-all, aborts updates
//   btb_fsm_branch_taken          direction offered to the counter FSM (READ)
//   btb_fsm_current_prediction    counter offered to the counter FSM (READ)
//   btb_fsm_new_prediction        updated counter from the FSM (used in WRITE)
module branch_target_buffer #(
    parameter int BTB_INDEX_BITS = 4
) (
    input  logic        btb_clk,
    input  logic        btb_rst,
    input  logic [31:0] btb_fetch_pc,
    output logic        btb_hit,
    output logic        btb_predict_taken,
    output logic [31:0] btb_predicted_target,
    input  logic        btb_update_valid,
    output logic        btb_update_ready,
    input  logic [31:0] btb_update_pc,
    input  logic        btb_update_taken,
    input  logic [31:0] btb_update_target,
    input  logic        btb_flush,
    output logic        btb_fsm_branch_taken,
    output logic [1:0]  btb_fsm_current_prediction,
    input  logic [1:0]  btb_fsm_new_prediction
);

    localparam int ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_W   = 30 - BTB_INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t state;

    logic [ENTRIES-1:0] valid_mem;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    // Update data captured at the accept edge
    logic [BTB_INDEX_BITS-1:0] upd_index;
    logic [TAG_W-1:0]          upd_tag;
    logic                      upd_taken;
    logic [31:0]               upd_target;
    logic                      upd_hit;

    logic [BTB_INDEX_BITS-1:0] fetch_index;
    logic [TAG_W-1:0]          fetch_tag;
    logic [BTB_INDEX_BITS-1:0] in_index;
    logic [TAG_W-1:0]          in_tag;
    logic                      in_hit;
    logic                      unused_pc_bits;

    assign fetch_index = btb_fetch_pc[BTB_INDEX_BITS+1:2];
    assign fetch_tag   = btb_fetch_pc[31:BTB_INDEX_BITS+2];
    assign in_index    = btb_update_pc[BTB_INDEX_BITS+1:2];
    assign in_tag      = btb_update_pc[31:BTB_INDEX_BITS+2];
    assign in_hit      = valid_mem[in_index] && (tag_mem[in_index] == in_tag);

    // Byte offset within the instruction word plays no part in indexing
    assign unused_pc_bits = ^{btb_fetch_pc[1:0], btb_update_pc[1:0]};

    assign btb_hit              = valid_mem[fetch_index] && (tag_mem[fetch_index] == fetch_tag);
    assign btb_predict_taken    = btb_hit && ctr_mem[fetch_index][1];
    assign btb_predicted_target = btb_hit ? target_mem[fetch_index] : '0;
    assign btb_update_ready     = (state == IDLE);

    always_ff @(posedge btb_clk or posedge btb_rst) begin
        if (btb_rst) begin
            state                      <= IDLE;
            valid_mem                  <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= 2'b01;
            end
            upd_index                  <= '0;
            upd_tag                    <= '0;
            upd_taken                  <= 1'b0;
            upd_target                 <= '0;
            upd_hit                    <= 1'b0;
            btb_fsm_branch_taken       <= 1'b0;
            btb_fsm_current_prediction <= 2'b00;
        end else if (btb_flush) begin
            // Flush beats both a pending accept and a pending WRITE; counters
            // and targets are deliberately left in place.
            state                      <= IDLE;
            valid_mem                  <= '0;
            btb_fsm_branch_taken       <= 1'b0;
            btb_fsm_current_prediction <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (btb_update_valid) begin
                        upd_index  <= in_index;
                        upd_tag    <= in_tag;
                        upd_taken  <= btb_update_taken;
                        upd_target <= btb_update_target;
                        upd_hit    <= in_hit;
                        // FSM-facing outputs are registered so they are
                        // already valid throughout READ.
                        btb_fsm_branch_taken       <= btb_update_taken;
                        btb_fsm_current_prediction <= in_hit ? ctr_mem[in_index] : 2'b01;
                        state <= READ;
                    end
                end
                READ: begin
                    btb_fsm_branch_taken       <= 1'b0;
                    btb_fsm_current_prediction <= 2'b00;
                    state                      <= WRITE;
                end
                WRITE: begin
                    if (upd_hit) begin
                        ctr_mem[upd_index] <= btb_fsm_new_prediction;
                        if (upd_taken) begin
                            target_mem[upd_index] <= upd_target;
                        end
                    end else if (upd_taken) begin
                        valid_mem[upd_index]  <= 1'b1;
                        tag_mem[upd_index]    <= upd_tag;
                        target_mem[upd_index] <= upd_target;
                        ctr_mem[upd_index]    <= btb_fsm_new_prediction;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
